// File: rtl/pll_lock_rst_gen.sv
// pll_lock_rst_gen: PLL lock qualifier, PLL reset retry on timeout, downstream reset release after stable lock.
module pll_lock_rst_gen #(
  parameter int PLL_RST_CYC      = 64,
  parameter int LOCK_TIMEOUT_CYC = 500000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int RST_HOLD_CYC     = 16,
  parameter int CNT_W            = 20,
  parameter int EVT_W            = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             rst_n_out,
  output logic             locked_ok,
  output logic [EVT_W-1:0] lock_loss_cnt,
  output logic [EVT_W-1:0] timeout_cnt,
  output logic [2:0]       state_dbg
);
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4
  } state_t;
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             lock_m, lock_s;
  logic             timeout_evt, loss_evt;
  assign state_dbg = state;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) {lock_s, lock_m} <= 2'b00;
    else {lock_s, lock_m} <= {lock_m, pll_lock};
  // Lock has priority over the timeout when both hit in WAIT_LOCK.
  always_comb begin
    state_nx    = state;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
    case (state)
      PLL_RST:   state_nx = (cnt >= RST_LAST) ? WAIT_LOCK : PLL_RST;
      WAIT_LOCK: begin
        state_nx    = lock_s ? STABLE : (cnt == TO_LAST) ? PLL_RST : WAIT_LOCK;
        timeout_evt = !lock_s && cnt == TO_LAST;
      end
      STABLE:    state_nx = !lock_s ? WAIT_LOCK : (cnt == STB_LAST) ? HOLD : STABLE;
      HOLD:      state_nx = !lock_s ? WAIT_LOCK : (cnt == HOLD_LAST) ? RUN : HOLD;
      RUN: begin
        state_nx = lock_s ? RUN : WAIT_LOCK;
        loss_evt = !lock_s;
      end
      default:   state_nx = PLL_RST;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state         <= PLL_RST;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      rst_n_out     <= 1'b0;
      locked_ok     <= 1'b0;
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= (state_nx != state) ? '0 : cnt + 1'b1;
      pll_rst       <= state_nx == PLL_RST;
      rst_n_out     <= state_nx == RUN;
      locked_ok     <= state_nx == RUN;
      lock_loss_cnt <= (loss_evt && !(&lock_loss_cnt)) ? lock_loss_cnt + 1'b1 : lock_loss_cnt;
      timeout_cnt   <= (timeout_evt && !(&timeout_cnt)) ? timeout_cnt + 1'b1 : timeout_cnt;
    end
endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// tb_pll_lock_rst_gen: directed checks of lock qualification, timeouts, lock loss and async reset.
module tb_pll_lock_rst_gen;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pll_lock = 1'b1;
  logic       pll_rst, rst_n_out, locked_ok;
  logic [1:0] lock_loss_cnt, timeout_cnt;
  logic [2:0] state_dbg;
  logic       saw_rst = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;
  pll_lock_rst_gen #(
    .PLL_RST_CYC(5), .LOCK_TIMEOUT_CYC(50), .LOCK_STABLE_CYC(8),
    .RST_HOLD_CYC(4), .CNT_W(20), .EVT_W(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .rst_n_out(rst_n_out), .locked_ok(locked_ok),
    .lock_loss_cnt(lock_loss_cnt), .timeout_cnt(timeout_cnt), .state_dbg(state_dbg)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) if (pll_rst) saw_rst <= 1'b1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask
  initial begin
    #23;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    check("rst_state", state_dbg, 0);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_rst_n_out", rst_n_out, 0);
    check("rst_locked_ok", locked_ok, 0);
    tick(4);
    check("t1_pll_rst_e4", pll_rst, 1);
    tick(1);
    check("t1_pll_rst_e5", pll_rst, 0);
    check("t1_state_e5", state_dbg, 1);
    tick(12);
    check("t1_state_e17", state_dbg, 3);
    check("t1_rst_n_e17", rst_n_out, 0);
    tick(1);
    check("t1_rst_n_e18", rst_n_out, 1);
    check("t1_locked_e18", locked_ok, 1);
    check("t1_state_e18", state_dbg, 4);
    check("t1_loss", lock_loss_cnt, 0);
    check("t1_timeout", timeout_cnt, 0);
    pll_lock = 1'b0;
    tick(2);
    check("t3_rst_n_e2", rst_n_out, 1);
    tick(1);
    check("t3_rst_n_e3", rst_n_out, 0);
    check("t3_locked_e3", locked_ok, 0);
    check("t3_state_e3", state_dbg, 1);
    check("t3_loss", lock_loss_cnt, 1);
    saw_rst = 1'b0;
    pll_lock = 1'b1;
    tick(14);
    check("t3_state_pre", state_dbg, 3);
    check("t3_rst_n_pre", rst_n_out, 0);
    tick(1);
    check("t3_rst_n_back", rst_n_out, 1);
    check("t3_no_pll_rst", saw_rst, 0);
    pll_lock = 1'b0;
    tick(3);
    check("t4_loss", lock_loss_cnt, 2);
    pll_lock = 1'b1;
    tick(3);
    check("t4_stable", state_dbg, 2);
    tick(2);
    pll_lock = 1'b0;
    tick(3);
    check("t4_back_wait", state_dbg, 1);
    check("t4_rst_n_low", rst_n_out, 0);
    pll_lock = 1'b1;
    tick(3);
    check("t4_restable", state_dbg, 2);
    tick(7);
    check("t4_still_stable", state_dbg, 2);
    tick(1);
    check("t4_hold", state_dbg, 3);
    tick(3);
    check("t4_still_hold", state_dbg, 3);
    tick(1);
    check("t4_run", state_dbg, 4);
    check("t4_loss_same", lock_loss_cnt, 2);
    check("t4_timeout_same", timeout_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      pll_lock = 1'b0;
      tick(3);
      pll_lock = 1'b1;
      tick(15);
    end
    check("t6_run", state_dbg, 4);
    check("t6_loss_sat", lock_loss_cnt, 3);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t6_async_pll_rst", pll_rst, 1);
    check("t6_async_rst_n", rst_n_out, 0);
    check("t6_async_locked", locked_ok, 0);
    check("t6_async_loss", lock_loss_cnt, 0);
    check("t6_async_state", state_dbg, 0);
    pll_lock = 1'b0;
    #20;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    tick(54);
    check("t2_e54_state", state_dbg, 1);
    check("t2_e54_to", timeout_cnt, 0);
    tick(1);
    check("t2_e55_to", timeout_cnt, 1);
    check("t2_e55_pll_rst", pll_rst, 1);
    tick(4);
    check("t2_e59_pll_rst", pll_rst, 1);
    tick(1);
    check("t2_e60_pll_rst", pll_rst, 0);
    tick(50);
    check("t2_e110_to", timeout_cnt, 2);
    check("t2_e110_state", state_dbg, 0);
    tick(52);
    pll_lock = 1'b1;
    tick(2);
    check("t5_e164_state", state_dbg, 1);
    tick(1);
    check("t5_e165_state", state_dbg, 2);
    check("t5_e165_to", timeout_cnt, 2);
    check("t5_e165_pll_rst", pll_rst, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
